// File: rtl/c3aibadapt_rx_cfg_seq.sv
// RX adapter reconfiguration sequencer: quiesces the RX FIFO, swaps in a staged
// config word, pulses the FIFO pointer reset, settles, then resumes traffic.
module c3aibadapt_rx_cfg_seq #(
  parameter int               CFG_W      = 32,
  parameter logic [CFG_W-1:0] RESET_CFG  = '0,
  parameter int               DRAIN_TO   = 255,
  parameter int               RST_CYC    = 2,
  parameter int               SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_req,
  input  logic [CFG_W-1:0] cfg_new,
  input  logic             fifo_empty,
  output logic             stop_write,
  output logic             stop_read,
  output logic             fifo_rst,
  output logic [CFG_W-1:0] cfg_active,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             busy
);

  localparam int MAX_AB  = (DRAIN_TO > RST_CYC) ? DRAIN_TO : RST_CYC;
  localparam int MAX_ALL = (MAX_AB > SETTLE_CYC) ? MAX_AB : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TO - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, STOP_WR, DRAIN, STOP_RD, APPLY, FRST, SETTLE, RESUME
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CFG_W-1:0]   staging_reg;
  logic               armed_reg;
  logic               drain_timeout;

  assign drain_timeout = (state_reg == DRAIN) && !fifo_empty && (cnt_reg == DRAIN_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE:    if (cfg_req && armed_reg) state_next = STOP_WR;
      STOP_WR: begin
        state_next = DRAIN;
        cnt_next   = '0;
      end
      DRAIN: begin
        // An empty FIFO takes priority over a coincident timeout.
        if (fifo_empty || cnt_reg == DRAIN_LAST) state_next = STOP_RD;
        else cnt_next = cnt_reg + 1'b1;
      end
      STOP_RD: state_next = APPLY;
      APPLY: begin
        state_next = FRST;
        cnt_next   = '0;
      end
      FRST: begin
        if (cnt_reg == RST_LAST) begin
          cnt_next   = '0;
          state_next = (SETTLE_CYC > 0) ? SETTLE : RESUME;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_reg == SETTLE_LAST) state_next = RESUME;
        else cnt_next = cnt_reg + 1'b1;
      end
      RESUME:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      staging_reg <= RESET_CFG;
      armed_reg   <= 1'b1;
      cfg_active  <= RESET_CFG;
      cfg_err     <= 1'b0;
      stop_write  <= 1'b0;
      stop_read   <= 1'b0;
      fifo_rst    <= 1'b0;
      cfg_ack     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      // A request must be seen low in IDLE before another one is accepted.
      if (state_reg == IDLE) begin
        if (!cfg_req) begin
          armed_reg <= 1'b1;
        end else if (armed_reg) begin
          armed_reg   <= 1'b0;
          staging_reg <= cfg_new;
          cfg_err     <= 1'b0;
        end
      end
      if (drain_timeout) cfg_err <= 1'b1;
      if (state_reg == APPLY) cfg_active <= staging_reg;

      // Outputs are a registered decode of the state being entered.
      stop_write <= (state_next inside {STOP_WR, DRAIN, STOP_RD, APPLY, FRST, SETTLE});
      stop_read  <= (state_next inside {STOP_RD, APPLY, FRST, SETTLE});
      fifo_rst   <= (state_next == FRST);
      cfg_ack    <= (state_next == RESUME);
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/c3aibadapt_rx_cfg_seq.md
Name: c3aibadapt_rx_cfg_seq

Overview:
Reconfiguration sequencer for the RX adapter datapath. It accepts a request to apply a new datapath configuration word, quiesces the RX FIFO (stop write, drain, stop read), loads the staged word, pulses the FIFO pointer reset, waits a settle interval and resumes traffic. It sits between the RX DPRIO register block (config source) and the RX datapath FIFO, driving its stop_write/stop_read controls and the active config word.

Parameters:
CFG_W, 32, width of config word (packs fifo_mode, thresholds, phcomp delay, etc.)
RESET_CFG, 0, value of cfg_active after reset
DRAIN_TO, 255, max DRAIN cycles before forced advance (>=1)
RST_CYC, 2, fifo_rst pulse length in cycles (>=1)
SETTLE_CYC, 4, settle cycles after FIFO reset (0 = SETTLE state skipped)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_req  in  1  level request to apply cfg_new; held until cfg_ack
cfg_new  in  CFG_W  new config word; sampled only on accept
fifo_empty  in  1  RX FIFO empty status (clk domain)
stop_write  out  1  RX FIFO write-stop control
stop_read  out  1  RX FIFO read-stop control
fifo_rst  out  1  RX FIFO pointer reset
cfg_active  out  CFG_W  config word applied to datapath
cfg_ack  out  1  one-cycle completion pulse
cfg_err  out  1  sticky drain-timeout flag
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at edge, any state): state=IDLE, cfg_active=RESET_CFG, stop_write=stop_read=fifo_rst=cfg_ack=cfg_err=busy=0, counter=0, armed=1.
- All outputs registered or Moore decodes of registered state; no combinational input->output paths.
- States: IDLE, STOP_WR, DRAIN, STOP_RD, APPLY, FRST, SETTLE, RESUME.
- IDLE: if cfg_req && armed -> STOP_WR; capture cfg_new into staging reg; clear cfg_err; armed<=0. armed<=1 whenever cfg_req sampled 0 in IDLE. Holding cfg_req high after ack does not retrigger.
- STOP_WR (1 cycle): stop_write=1 -> DRAIN, counter<=0.
- DRAIN: stop_write=1. fifo_empty=1 -> STOP_RD. Else counter++; if counter==DRAIN_TO-1 -> cfg_err<=1, STOP_RD. Empty and timeout same cycle: empty wins, no error. DRAIN lasts at most DRAIN_TO cycles.
- STOP_RD (1 cycle): stop_write=stop_read=1 -> APPLY.
- APPLY (1 cycle): stops held; cfg_active<=staging (visible next cycle) -> FRST, counter<=0.
- FRST: stops held, fifo_rst=1 for exactly RST_CYC cycles -> SETTLE (or RESUME if SETTLE_CYC=0).
- SETTLE: stops held, fifo_rst=0, SETTLE_CYC cycles -> RESUME.
- RESUME (1 cycle): stop_write=stop_read=0, cfg_ack=1, busy=1 -> IDLE.
- cfg_new changes after accept are ignored; cfg_req dropped mid-sequence does not abort.
- cfg_err holds until next accepted request or reset.
- Latency (empty FIFO, RST_CYC=2, SETTLE_CYC=4): req sampled at cycle 0; STOP_WR 1, DRAIN 2, STOP_RD 3, APPLY 4, cfg_active new at 5, fifo_rst 5-6, SETTLE 7-10, cfg_ack 11, IDLE 12.
- Counter width = clog2(max(DRAIN_TO, RST_CYC, SETTLE_CYC)+1).

Test Plan:
- Reset then idle: rst 3 cycles -> cfg_active=RESET_CFG, all controls 0, busy=0; held cfg_req=0 -> no activity.
- Nominal (defaults, fifo_empty=1, cfg_new=0xA5A5_0003): cfg_ack exactly at cycle 11, cfg_active=0xA5A5_0003 from cycle 5, fifo_rst high cycles 5-6 only, stop_write cycles 1-10, stop_read 3-10, cfg_err=0.
- Slow drain: fifo_empty rises 10 cycles into DRAIN -> STOP_RD next cycle, ack delayed 10 cycles vs nominal, cfg_err=0; empty on same cycle as timeout (DRAIN_TO=8) -> cfg_err=0.
- Timeout: fifo_empty stuck 0, DRAIN_TO=8 -> DRAIN exactly 8 cycles, cfg_err=1 sticky through ack, cleared on next accept.
- Re-arm / stability: cfg_req held high 30 cycles after ack -> single ack; change cfg_new during DRAIN -> cfg_active takes captured value; drop then raise -> second sequence runs.
- Reset mid-sequence: rst during FRST -> next cycle fifo_rst=0, stops=0, cfg_active=RESET_CFG, state IDLE, no cfg_ack.
